counter_driver: RTL and testbench

Command-side initiator for the 4-bit loadable up/down counter. Accepts a target value over a valid/ready handshake. Drives the counter's load/hold/count_up/count_down/En/initial_value inputs until the counter output equals the target, then pulses done. Sits between control logic and the counter; the counter's out is fed back as cur_value.

---
 rtl/cnt_drv_pkg.sv | 23 ++
 rtl/cnt_drv_dist.sv | 32 +++
 rtl/counter_driver.sv | 145 ++++++++++++++
 tb/tb_counter_driver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cnt_drv_pkg.sv
// Shared definitions for the counter driver: FSM state encodings,
// request mode constants and the stepping direction type.
package cnt_drv_pkg;

    localparam int WIDTH_DEF = 4;

    // FSM state encodings (kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_STEP   = 3'd2;
    localparam logic [2:0] ST_VERIFY = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Request modes carried on tgt_mode
    localparam logic MODE_STEP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/cnt_drv_dist.sv
// Modular distance from cur to tgt on a WIDTH-bit ring. Picks the
// shorter direction; an exact half-turn goes up.
module cnt_drv_dist
    import cnt_drv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    output dir_e             dir,
    output logic [WIDTH-1:0] n,
    output logic             zero
);

    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] d;

    // Forward distance wraps naturally in WIDTH-bit arithmetic
    always_comb begin
        d    = tgt - cur;
        zero = (d == '0);
        if (d <= HALF) begin
            dir = DIR_UP;
            n   = d;
        end else begin
            dir = DIR_DOWN;
            n   = '0 - d;   // 2^WIDTH - d
        end
    end

endmodule

// File: rtl/counter_driver.sv
// Command-side initiator for the loadable up/down counter. Accepts a
// target over valid/ready, steps or loads the counter until it reaches
// the target, then pulses done.
// Optional feature macro: CNT_DRV_VERIFY_EN (adds the VERIFY state and
// the feedback compare that drives err).
module counter_driver
    import cnt_drv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_value,
    input  logic             tgt_mode,
    input  logic [WIDTH-1:0] cur_value,
    output logic             en,
    output logic             load,
    output logic             hold,
    output logic             count_up,
    output logic             count_down,
    output logic [WIDTH-1:0] initial_value,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef CNT_DRV_VERIFY_EN
    localparam logic [2:0] ST_FINISH = ST_VERIFY;
`else
    localparam logic [2:0] ST_FINISH = ST_DONE;
`endif

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] init_q, init_d;
    dir_e             dir_q, dir_d;
`ifdef CNT_DRV_VERIFY_EN
    logic             err_q, err_d;
`endif

    dir_e             dist_dir;
    logic [WIDTH-1:0] dist_n;
    logic             dist_zero;

    cnt_drv_dist #(.WIDTH(WIDTH)) u_dist (
        .cur  (cur_value),
        .tgt  (tgt_value),
        .dir  (dist_dir),
        .n    (dist_n),
        .zero (dist_zero)
    );

    // Next-state logic for the request FSM and its working registers
    always_comb begin
        // NOTE: every signal gets its hold value first so no latch is inferred.
        state_d = state_q;
        tgt_d   = tgt_q;
        n_d     = n_q;
        init_d  = init_q;
        dir_d   = dir_q;
`ifdef CNT_DRV_VERIFY_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tgt_valid) begin
                    tgt_d = tgt_value;
                    if (tgt_mode == MODE_LOAD) begin
                        // Present the target on initial_value during the LOAD cycle
                        init_d  = tgt_value;
                        state_d = ST_LOAD;
                    end else if (dist_zero) begin
                        state_d = ST_FINISH;
                    end else begin
                        dir_d   = dist_dir;
                        n_d     = dist_n;
                        state_d = ST_STEP;
                    end
                end
            end
            ST_LOAD: state_d = ST_FINISH;
            ST_STEP: begin
                n_d = n_q - WIDTH'(1);
                if (n_q == WIDTH'(1)) begin
                    state_d = ST_FINISH;
                end
            end
`ifdef CNT_DRV_VERIFY_EN
            ST_VERIFY: begin
                err_d   = (cur_value != tgt_q);
                state_d = ST_DONE;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            n_q     <= '0;
            init_q  <= '0;
            dir_q   <= DIR_UP;
`ifdef CNT_DRV_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            n_q     <= n_d;
            init_q  <= init_d;
            dir_q   <= dir_d;
`ifdef CNT_DRV_VERIFY_EN
            err_q   <= err_d;
`endif
        end
    end

    // While reset is asserted the outputs already show IDLE values
    logic [2:0] st_view;
    assign st_view = reset ? ST_IDLE : state_q;

    assign en            = 1'b1;
    assign tgt_ready     = (st_view == ST_IDLE) && !reset;
    assign hold          = (st_view == ST_IDLE) || (st_view == ST_VERIFY) || (st_view == ST_DONE);
    assign load          = (st_view == ST_LOAD);
    assign count_up      = (st_view == ST_STEP) && (dir_q == DIR_UP);
    assign count_down    = (st_view == ST_STEP) && (dir_q == DIR_DOWN);
    assign initial_value = reset ? '0 : init_q;
    assign busy          = (st_view != ST_IDLE);
    assign done          = (st_view == ST_DONE);
`ifdef CNT_DRV_VERIFY_EN
    assign err           = done && err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_counter_driver.sv
// Directed bench for counter_driver driving a behavioural 4-bit
// loadable up/down counter whose output is fed back as cur_value.
// Expected latencies follow CNT_DRV_VERIFY_EN when it is defined.
module tb_counter_driver;

`ifdef CNT_DRV_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif
    localparam int SH = 1 - VER;   // latency reduction without VERIFY

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] tgt_value = 4'd0;
    logic       tgt_mode = 1'b0;
    logic [3:0] cur_value;
    logic       en, load, hold, count_up, count_down;
    logic [3:0] initial_value;
    logic       busy, done, err;

    int errors = 0;
    int checks = 0;

    // Behavioural counter plus bench hooks to preset or freeze it
    logic       set_req = 1'b0;
    logic [3:0] set_val = 4'd0;
    logic       stuck = 1'b0;
    logic [3:0] cnt = 4'd0;
    assign cur_value = cnt;

    always #5 clk = ~clk;

    // Counter model: load > hold > up > down when enabled
    always @(posedge clk) begin
        if (set_req) cnt <= set_val;
        else if (!stuck && en) begin
            if (load)            cnt <= initial_value;
            else if (hold)       cnt <= cnt;
            else if (count_up)   cnt <= cnt + 4'd1;
            else if (count_down) cnt <= cnt - 4'd1;
        end
    end

    counter_driver #(.WIDTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .tgt_valid     (tgt_valid),
        .tgt_ready     (tgt_ready),
        .tgt_value     (tgt_value),
        .tgt_mode      (tgt_mode),
        .cur_value     (cur_value),
        .en            (en),
        .load          (load),
        .hold          (hold),
        .count_up      (count_up),
        .count_down    (count_down),
        .initial_value (initial_value),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic preset(input logic [3:0] v);
        @(negedge clk);
        set_req = 1'b1;
        set_val = v;
        @(negedge clk);
        set_req = 1'b0;
    endtask

    // Offer a request at a negedge; returns after the accept edge
    task automatic start(input string tag, input logic [3:0] tgt, input logic mode);
        @(negedge clk);
        check({tag, "_ready"}, tgt_ready, 1);
        tgt_valid = 1'b1;
        tgt_value = tgt;
        tgt_mode  = mode;
        @(posedge clk);
    endtask

    // Full request: monitor pulses until done, then compare everything
    task automatic request(input string tag, input logic [3:0] tgt, input logic mode,
                           input bit keep_valid, input int exp_cyc, input int exp_err,
                           input int exp_up, input int exp_dn, input int exp_ld,
                           input logic [3:0] exp_final);
        int ups = 0, dns = 0, lds = 0, cyc = 0, multi = 0, rdy_busy = 0;
        logic got = 1'b0;
        logic e = 1'b0;
        logic [3:0] ldval = 4'd0;
        start(tag, tgt, mode);
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (keep_valid) tgt_value = ~tgt;   // must be ignored while busy
            else            tgt_valid = 1'b0;
            if (32'(load) + 32'(hold) + 32'(count_up) + 32'(count_down) > 1) multi++;
            if (tgt_ready) rdy_busy++;
            ups += 32'(count_up);
            dns += 32'(count_down);
            lds += 32'(load);
            if (load) ldval = initial_value;
            if (done) begin
                got = 1'b1;
                cyc = k;
                e   = err;
            end
        end
        tgt_valid = 1'b0;
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_done_cycle"}, cyc, exp_cyc);
        check({tag, "_err"}, e, exp_err);
        check({tag, "_ups"}, ups, exp_up);
        check({tag, "_downs"}, dns, exp_dn);
        check({tag, "_loads"}, lds, exp_ld);
        check({tag, "_onehot"}, multi, 0);
        check({tag, "_ready_busy"}, rdy_busy, 0);
        if (exp_ld != 0) check({tag, "_ldval"}, ldval, tgt);
        @(negedge clk);
        check({tag, "_final"}, cnt, exp_final);
    endtask

    initial begin
        int seen;
        // Reset state
        @(negedge clk);
        check("rst_ready", tgt_ready, 0);
        check("rst_en", en, 1);
        check("rst_hold", hold, 1);
        check("rst_pulses", {load, count_up, count_down}, 0);
        check("rst_flags", {busy, done, err}, 0);
        check("rst_initval", initial_value, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_ready", tgt_ready, 1);

        // Step up 2 -> 5: three up pulses
        preset(4'd2);
        request("up3", 4'd5, 1'b0, 1'b0, 5 - SH, 0, 3, 0, 0, 4'd5);
        // Step down 1 -> 14: distance 13 goes down 3
        preset(4'd1);
        request("dn3", 4'd14, 1'b0, 1'b0, 5 - SH, 0, 0, 3, 0, 4'd14);
        // Tie 0 -> 8 goes up 8
        preset(4'd0);
        request("tie", 4'd8, 1'b0, 1'b0, 10 - SH, 0, 8, 0, 0, 4'd8);
        // Direct load of 9
        preset(4'd4);
        request("ld9", 4'd9, 1'b1, 1'b0, 3 - SH, 0, 0, 0, 1, 4'd9);
        check("ld9_initval_held", initial_value, 9);
        // Zero distance with valid held through busy, then back-to-back
        preset(4'd7);
        request("zero", 4'd7, 1'b0, 1'b1, 2 - SH, 0, 0, 0, 0, 4'd7);
        request("b2b", 4'd6, 1'b0, 1'b0, 3 - SH, 0, 0, 1, 0, 4'd6);
        // Wrap 15 -> 0 with one up pulse
        preset(4'd15);
        request("wrap", 4'd0, 1'b0, 1'b0, 3 - SH, 0, 1, 0, 0, 4'd0);
        // Counter frozen at 3: pulses issue, err only with VERIFY
        preset(4'd3);
        stuck = 1'b1;
        request("stuck", 4'd6, 1'b0, 1'b0, 5 - SH, VER, 3, 0, 0, 4'd3);
        stuck = 1'b0;

        // Reset during the second STEP cycle of a 5-step request
        preset(4'd0);
        start("rstmid", 4'd5, 1'b0);
        @(negedge clk);
        tgt_valid = 1'b0;
        check("rstmid_step1", count_up, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_hold", hold, 1);
        check("rstmid_up", count_up, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_ready", tgt_ready, 1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seen += 32'(done);
        end
        check("rstmid_no_done", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
